// File: rtl/mux_rr_stream.sv
// N_CH-channel valid/ready stream multiplexer with round-robin arbitration and a registered output stage.
// Optional build macro MUX_FORCE_SEL_EN adds force_en/force_sel to pin arbitration to one channel.
module mux_rr_stream #(
    parameter  int WIDTH = 4,
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef MUX_FORCE_SEL_EN
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel,
`endif
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [N_CH-1:0]  eligible;
    logic             force_active;
    logic [SEL_W-1:0] grant;
    logic             grant_found;
    logic             load_en;
    logic             transfer;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Channels allowed to compete this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        eligible = in_valid;
`ifdef MUX_FORCE_SEL_EN
        force_active = force_en;
        if (force_en) begin
            eligible = '0;
            if (int'(force_sel) < N_CH) begin
                eligible[force_sel] = in_valid[force_sel];
            end
        end
`else
        force_active = 1'b0;
`endif
    end

    // Rotating priority scan starting at ptr_q, wrapping modulo N_CH.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant       = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        load_en  = !out_valid_q || out_ready;
        transfer = rst_n && grant_found && load_en;

        in_ready = '0;
        if (transfer) begin
            in_ready[grant] = 1'b1;
        end

        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            // Loading while draining replaces the old word in the same edge, so no bubble.
            out_data_d  = in_data[int'(grant)*WIDTH +: WIDTH];
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            if (!force_active) begin
                ptr_d = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments; the comb blocks above use blocking.
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Scoreboard bench for mux_rr_stream (WIDTH=4, N_CH=4, channel data 4,8,1,15).
// The forced-selection test runs only when MUX_FORCE_SEL_EN is defined.
module tb_mux_rr_stream;

    localparam int WIDTH = 4;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] ch;
    } word_t;

    logic                  clk;
    logic                  rst_n;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;
`ifdef MUX_FORCE_SEL_EN
    logic                  force_en;
    logic [SEL_W-1:0]      force_sel;
`endif

    int    total = 0;
    int    bad   = 0;
    word_t exp_q[$];

    mux_rr_stream #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUX_FORCE_SEL_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] c, input int n);
        word_t w;
        w.data = d;
        w.ch   = c;
        for (int i = 0; i < n; i++) exp_q.push_back(w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'd1, 32'd0);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(w.data));
                check("sb_ch", 32'(out_ch), 32'(w.ch));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_data   = {4'd15, 4'd1, 4'd8, 4'd4};
        in_valid  = '0;
        out_ready = 1'b0;
`ifdef MUX_FORCE_SEL_EN
        force_en  = 1'b0;
        force_sel = '0;
`endif
        rst_n = 1'b0;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ch", 32'(out_ch), 32'd0);
        step();
        rst_n = 1'b1;

        // 1. Reset mid-stream with a held word.
        in_valid = 4'b1111;
        step();
        @(negedge clk);
        check("held_valid", 32'(out_valid), 32'd1);
        check("held_data", 32'(out_data), 32'd4);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_ch", 32'(out_ch), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid  = '0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // 2. All channels valid for 8 cycles: rotation from ptr=0.
        push(4'd4, 2'd0, 1); push(4'd8, 2'd1, 1); push(4'd1, 2'd2, 1); push(4'd15, 2'd3, 1);
        push(4'd4, 2'd0, 1); push(4'd8, 2'd1, 1); push(4'd1, 2'd2, 1); push(4'd15, 2'd3, 1);
        in_valid = 4'b1111;
        #1;
        check("first_in_ready", 32'(in_ready), 32'b0001);
        repeat (8) @(posedge clk);
        #1;
        in_valid = '0;
        wait_drain();

        // 3. Only ch2 valid, then ch1+ch3 with ptr=3.
        push(4'd1, 2'd2, 4);
        push(4'd15, 2'd3, 1);
        push(4'd8, 2'd1, 1);
        in_valid = 4'b0100;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 4'b1010;
        #1;
        check("ch3_first_ready", 32'(in_ready), 32'b1000);
        repeat (2) @(posedge clk);
        #1;
        in_valid = '0;
        wait_drain();
        check("drained_valid", 32'(out_valid), 32'd0);

        // 4. Backpressure for 5 cycles, then release with no bubble.
        push(4'd8, 2'd1, 1);
        push(4'd1, 2'd2, 1);
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        step();
        in_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'd8);
            check("bp_ch", 32'(out_ch), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        step();
        out_ready = 1'b1;
        step();
        in_valid = '0;
        @(negedge clk);
        check("no_bubble_valid", 32'(out_valid), 32'd1);
        check("no_bubble_data", 32'(out_data), 32'd1);
        wait_drain();

        // 5. Single word from ch0 (ptr=3): one cycle of out_valid, data held afterwards.
        push(4'd4, 2'd0, 1);
        in_valid = 4'b0001;
        step();
        in_valid = '0;
        @(negedge clk);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'd4);
        @(negedge clk);
        check("single_drop", 32'(out_valid), 32'd0);
        check("hold_data", 32'(out_data), 32'd4);
        check("hold_ch", 32'(out_ch), 32'd0);
        step();

`ifdef MUX_FORCE_SEL_EN
        // 6. Forced channel 3; ptr (=1) must be untouched by forced transfers.
        push(4'd15, 2'd3, 4);
        push(4'd8, 2'd1, 1);
        force_en  = 1'b1;
        force_sel = 2'd3;
        in_valid  = 4'b1111;
        repeat (4) @(posedge clk);
        #1;
        force_en = 1'b0;
        step();
        force_en = 1'b1;
        in_valid = 4'b0111;
        @(negedge clk);
        check("force_none_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("force_none_valid", 32'(out_valid), 32'd0);
        check("force_hold_data", 32'(out_data), 32'd8);
        force_en = 1'b0;
        in_valid = '0;
        step();
`endif

        wait_drain();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
